// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the single register-file write port, with youngest-match forwarding lookup.
// Optional WBQ_STATS_EN adds a saturating 16-bit stall-cycle counter output (stall_cnt_o).
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_data_i,
    input  logic          alu_we_i,
    input  logic [AW-1:0] alu_addr_i,
    input  logic [DW-1:0] alu_data_i,
    output logic          in_ready_o,
    output logic          reg_write_o,
    output logic [AW-1:0] rd_addr_o,
    output logic [DW-1:0] rd_data_o,
    input  logic [AW-1:0] rs_addr_i,
    input  logic [AW-1:0] rt_addr_i,
    output logic          rs_hit_o,
    output logic [DW-1:0] rs_data_o,
    output logic          rt_hit_o,
    output logic [DW-1:0] rt_data_o
`ifdef WBQ_STATS_EN
    ,
    output logic [15:0]   stall_cnt_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;

    logic          w_push_mem, w_push_alu, w_pop;
    logic [CW-1:0] w_npush;
    logic [PW-1:0] w_alu_idx;

    assign in_ready_o = (r_count <= CW'(DEPTH - 2));
    // Writes to r0 are architecturally void, so they never take a slot.
    assign w_push_mem = in_ready_o && mem_we_i && (mem_addr_i != '0);
    assign w_push_alu = in_ready_o && alu_we_i && (alu_addr_i != '0);
    assign w_npush    = CW'(w_push_mem) + CW'(w_push_alu);
    assign w_alu_idx  = r_tail + PW'(w_push_mem);
    assign w_pop      = (r_count != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_npush);
            r_count <= r_count + w_npush - CW'(w_pop);
        end
    end

    // Payload storage needs no reset: every read is qualified by r_count.
    always_ff @(posedge clk_i) begin
        if (w_push_mem) begin
            r_addr[r_tail] <= mem_addr_i;
            r_data[r_tail] <= mem_data_i;
        end
        if (w_push_alu) begin
            r_addr[w_alu_idx] <= alu_addr_i;
            r_data[w_alu_idx] <= alu_data_i;
        end
    end

    assign reg_write_o = w_pop;
    assign rd_addr_o   = w_pop ? r_addr[r_head] : '0;
    assign rd_data_o   = w_pop ? r_data[r_head] : '0;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        rs_hit_o  = 1'b0;
        rs_data_o = '0;
        rt_hit_o  = 1'b0;
        rt_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_head + PW'(k);
            if (CW'(k) < r_count) begin
                if ((rs_addr_i != '0) && (r_addr[idx] == rs_addr_i)) begin
                    rs_hit_o  = 1'b1;
                    rs_data_o = r_data[idx];
                end
                if ((rt_addr_i != '0) && (r_addr[idx] == rt_addr_i)) begin
                    rt_hit_o  = 1'b1;
                    rt_data_o = r_data[idx];
                end
            end
        end
    end

`ifdef WBQ_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_stall_cnt <= '0;
        else if (!in_ready_o && (mem_we_i || alu_we_i) && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Sits between the writeback sources (ALU result path, load/MEM result path) and the single write port of the register file.
- Buffers up to DEPTH pending register writes in order and drains one per cycle into the register file write port.
- Exposes a lookup port so decode can forward the youngest pending value for rs/rt.
- Applies backpressure to the pipeline when it cannot accept another pair of writes.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset; asynchronous, active-high.
- mem_we_i  in  1  MEM-source write request (older instruction).
- mem_addr_i  in  AW  MEM-source destination register.
- mem_data_i  in  DW  MEM-source write data.
- alu_we_i  in  1  ALU-source write request (younger instruction).
- alu_addr_i  in  AW  ALU-source destination register.
- alu_data_i  in  DW  ALU-source write data.
- in_ready_o  out  1  queue can accept both sources this cycle.
- reg_write_o  out  1  write strobe to the register file.
- rd_addr_o  out  AW  write address to the register file.
- rd_data_o  out  DW  write data to the register file.
- rs_addr_i  in  AW  lookup address A.
- rt_addr_i  in  AW  lookup address B.
- rs_hit_o  out  1  a pending entry matches rs_addr_i.
- rs_data_o  out  DW  data of the youngest matching entry for rs; 0 if no hit.
- rt_hit_o  out  1  a pending entry matches rt_addr_i.
- rt_data_o  out  DW  data of the youngest matching entry for rt; 0 if no hit.

Behaviour:
- Storage: circular buffer with head pointer, tail pointer and count. count has width $clog2(DEPTH+1). Pointers wrap modulo DEPTH.
- Reset (asynchronous, any time, including mid-drain):
  - head, tail and count clear to 0; all entries are discarded.
  - Outputs while reset is asserted and on the first cycle after: reg_write_o=0, rd_addr_o=0, rd_data_o=0, rs_hit_o=0, rt_hit_o=0, rs_data_o=0, rt_data_o=0, in_ready_o=1.
- in_ready_o: combinational, equal to (count <= DEPTH-2). It depends on registered count only, never on the current cycle's inputs.
- Push, evaluated at posedge when in_ready_o=1:
  - A source is enqueued only if its we_i=1 and its addr != 0. Writes to register 0 are silently dropped and consume no slot.
  - If both sources qualify, the MEM entry goes at tail and the ALU entry at tail+1. The tail advances by the number of qualifying entries (0, 1 or 2).
  - If in_ready_o=0, both requests are ignored. Upstream must hold the requests (stall) until in_ready_o=1.
- Drain:
  - reg_write_o = (count != 0). rd_addr_o and rd_data_o are driven from the head entry, and forced to 0 when empty.
  - The register file consumes the write unconditionally, so head advances every cycle that count != 0.
  - Latency: a write pushed into an empty queue appears on reg_write_o the cycle after the push edge.
- Simultaneous push and pop: count_next = count + pushes - pop.
  - In a full queue, in_ready_o=0, so only the pop occurs.
  - With count=DEPTH-2, pushing 2 while popping 1 gives DEPTH-1.
- Lookup (combinational):
  - Scan all valid entries and select the youngest entry (nearest to tail) whose address matches.
  - Entries being pushed in the current cycle are not visible until the next cycle.
  - The head entry currently being written is visible.
  - Address 0 never hits.
- Ordering: register-file writes occur strictly in push order, so the final value of any register equals the youngest write.

Optional Feature:
- Macro: WBQ_STATS_EN.
- When defined:
  - Adds output stall_cnt_o (16 bits): counts cycles in which in_ready_o=0 and (mem_we_i | alu_we_i)=1.
  - Saturates at 16'hFFFF.
  - Cleared by rst_i.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then MEM write r3=0x11 and ALU write r4=0x22 in the same cycle → next cycle reg_write_o=1, rd_addr_o=3, rd_data_o=0x11; following cycle addr 4, data 0x22; then reg_write_o=0.
- ALU write r0=0xDEAD with no other traffic → no entry enqueued, reg_write_o stays 0, rs_hit_o=0 for rs_addr_i=0.
- Push pairs (r5=1,r6=2) and then (r5=3,r7=4) on consecutive cycles with DEPTH=4:
  - in_ready_o drops to 0 after the second push edge.
  - Lookup of r5 returns rs_hit_o=1, rs_data_o=3.
  - Register-file write order is r5,r6,r5,r7.
- Hold both requests while in_ready_o=0 → no entries lost or duplicated; the queue refills exactly once when space frees. With WBQ_STATS_EN, stall_cnt_o increments once per held cycle.
- Assert rst_i asynchronously while 3 entries are pending → outputs go to 0 immediately, without waiting for a clock edge. After release, the queue is empty and in_ready_o=1.
- Push 10 single writes spanning pointer wrap-around (DEPTH=4) → all 10 appear on the write port in order with correct data, with no write lost or duplicated across the wrap.
